program_user_clock_i2c: RTL and testbench

PROGRAM_USER_CLOCK_I2C -- requirements
Module: program_user_clock_i2c

---
 rtl/program_user_clock_pkg.sv | 23 ++
 rtl/i2c_quarter_tick.sv | 33 +++
 rtl/program_user_clock_i2c.sv | 151 +++++++++++++++
 tb/tb_program_user_clock_i2c.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_user_clock_pkg.sv
// Shared types for the Si570 user-clock I2C programmer.
// States, quarter index, byte-index sizing and the R/W bit.
package program_user_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef logic [1:0] quarter_t;

    localparam logic RW_WRITE = 1'b0;

    // Address byte + register byte + payload bytes.
    function automatic int byte_idx_w(input int num_bytes);
        return $clog2(num_bytes + 2);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-SCL-period strobe generator with enable and stretch hold.
// The hold only freezes the counter at 0 (start of a quarter).
module i2c_quarter_tick #(
    parameter int ClkDiv = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int CW = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(ClkDiv - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (hold && cnt == '0) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/program_user_clock_i2c.sv
// I2C write-only master that programs the user clock synthesiser.
// Define PROG_CLK_STRETCH_EN to add i_scl and honour slave clock stretching.
module program_user_clock_i2c
    import program_user_clock_pkg::*;
#(
    parameter int ClkDiv   = 250,
    parameter int NumBytes = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [6:0]            i_dev_addr,
    input  logic [7:0]            i_reg_addr,
    input  logic [NumBytes*8-1:0] i_data,
    input  logic                  i_sda,
`ifdef PROG_CLK_STRETCH_EN
    input  logic                  i_scl,
`endif
    output logic                  o_scl_oe,
    output logic                  o_sda_oe,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_nack
);

    localparam int TotalBytes = NumBytes + 2;
    localparam int BW         = byte_idx_w(NumBytes);

    state_t                    state;
    quarter_t                  q;
    logic [2:0]                bit_idx;
    logic [BW-1:0]             byte_idx;
    logic [TotalBytes*8-1:0]   frame;
    logic                      tick;
    logic                      hold;
    logic                      cur_bit;

    // frame[7:0] always holds the byte on the wire; MSB goes first.
    assign cur_bit = frame[~bit_idx];

`ifdef PROG_CLK_STRETCH_EN
    assign hold = (q == 2'd2) && !i_scl;
`else
    assign hold = 1'b0;
`endif

    i2c_quarter_tick #(
        .ClkDiv(ClkDiv)
    ) u_tick (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .en   (o_busy),
        .hold (hold),
        .tick (tick)
    );

    // Returns {scl_oe, sda_oe} for a given state/quarter/data bit.
    function automatic logic [1:0] drive(input state_t s, input quarter_t qq,
                                         input logic b);
        logic [1:0] d;
        d = 2'b00;
        unique case (s)
            ST_START: d = {&qq, qq[1]};
            ST_BIT:   d = {~qq[1], ~b};
            ST_ACK:   d = {~qq[1], 1'b0};
            ST_STOP:  d = {qq == 2'd0, qq != 2'd3};
            default:  d = 2'b00;
        endcase
        return d;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            q        <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            frame    <= '0;
            o_scl_oe <= 1'b0;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_nack   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        frame    <= {i_data, i_reg_addr, i_dev_addr, RW_WRITE};
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        q        <= '0;
                        o_nack   <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= ST_START;
                        {o_scl_oe, o_sda_oe} <= drive(ST_START, 2'd0, 1'b0);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    if (tick && q != 2'd3) begin
                        q <= q + 2'd1;
                        {o_scl_oe, o_sda_oe} <= drive(state, q + 2'd1, cur_bit);
                        if (state == ST_ACK && q == 2'd2 && i_sda) begin
                            o_nack <= 1'b1;
                        end
                    end else if (tick) begin
                        q <= '0;
                        unique case (state)
                            ST_START: begin
                                state   <= ST_BIT;
                                bit_idx <= '0;
                                {o_scl_oe, o_sda_oe} <= drive(ST_BIT, 2'd0, frame[7]);
                            end
                            ST_BIT: begin
                                if (bit_idx == 3'd7) begin
                                    state <= ST_ACK;
                                    {o_scl_oe, o_sda_oe} <= drive(ST_ACK, 2'd0, 1'b0);
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                    {o_scl_oe, o_sda_oe} <=
                                        drive(ST_BIT, 2'd0, frame[~(bit_idx + 3'd1)]);
                                end
                            end
                            ST_ACK: begin
                                if (o_nack || byte_idx == BW'(TotalBytes - 1)) begin
                                    state <= ST_STOP;
                                    {o_scl_oe, o_sda_oe} <= drive(ST_STOP, 2'd0, 1'b0);
                                end else begin
                                    state    <= ST_BIT;
                                    bit_idx  <= '0;
                                    byte_idx <= byte_idx + BW'(1);
                                    frame    <= frame >> 8;
                                    {o_scl_oe, o_sda_oe} <= drive(ST_BIT, 2'd0, frame[15]);
                                end
                            end
                            default: begin
                                state    <= ST_DONE;
                                o_done   <= 1'b1;
                                o_busy   <= 1'b0;
                                o_scl_oe <= 1'b0;
                                o_sda_oe <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_user_clock_i2c.sv
// Directed bench for program_user_clock_i2c (ClkDiv=4, NumBytes=2).
// Bus bytes are decoded from the oe lines and matched against a queue.
module tb_program_user_clock_i2c;

    localparam int ClkDiv   = 4;
    localparam int NumBytes = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        sda_in = 1'b0;
    logic        scl_in = 1'b1;
    logic [6:0]  dev    = 7'h5D;
    logic [7:0]  reg_a  = 8'h89;
    logic [15:0] data   = 16'h4010;
    logic        scl_oe, sda_oe, busy, done, nack;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_total = 0;
    int done_total = 0;
    int done_cyc = 0;
    int rise_cyc = 0;
    int bitcnt = 0;
    int nbytes = 0;
    int nstops = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] exp_q[$];
    logic prev_busy = 1'b0;
    logic prev_scl = 1'b0;
    logic prev_sda = 1'b0;

    program_user_clock_i2c #(
        .ClkDiv  (ClkDiv),
        .NumBytes(NumBytes)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_dev_addr(dev),
        .i_reg_addr(reg_a),
        .i_data    (data),
        .i_sda     (sda_in),
`ifdef PROG_CLK_STRETCH_EN
        .i_scl     (scl_in),
`endif
        .o_scl_oe  (scl_oe),
        .o_sda_oe  (sda_oe),
        .o_busy    (busy),
        .o_done    (done),
        .o_nack    (nack)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: START/STOP detection and byte decode on SCL release.
    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        if (busy) busy_total++;
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (busy && !prev_busy) rise_cyc = cyc;
        prev_busy = busy;
        if (!rst_n) begin
            bitcnt = 0;
        end else if (!prev_sda && sda_oe && !scl_oe && !prev_scl) begin
            bitcnt = 0;
            nbytes = 0;
        end else if (prev_sda && !sda_oe && !scl_oe && !prev_scl) begin
            nstops++;
            bitcnt = 0;
        end else if (prev_scl && !scl_oe) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], ~sda_oe};
                bitcnt++;
                if (bitcnt == 8) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    nbytes++;
                    chk("bus_byte", 32'(sh), 32'(e));
                end
            end else begin
                bitcnt = 0;
            end
        end
        prev_scl = scl_oe;
        prev_sda = sda_oe;
    end

    task automatic push_frame(input logic [6:0] d, input logic [7:0] r,
                              input logic [15:0] p);
        exp_q.push_back({d, 1'b0});
        exp_q.push_back(r);
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int b0, d0, s0, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl_oe), 0);
        chk("rst_sda", 32'(sda_oe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_nack", 32'(nack), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Full ACKed write
        push_frame(7'h5D, 8'h89, 16'h4010);
        b0 = busy_total;
        d0 = done_total;
        pulse_start();
        wait_done("t1_done", 1000);
        repeat (4) @(negedge clk);
        chk("t1_busy_cycles", 32'(busy_total - b0), 608);
        chk("t1_done_count", 32'(done_total - d0), 1);
        chk("t1_nack", 32'(nack), 0);
        chk("t1_bytes", 32'(nbytes), 4);
        chk("t1_queue_left", 32'(exp_q.size()), 0);

        // Address NACK
        sda_in = 1'b1;
        exp_q.push_back(8'hBA);
        b0 = busy_total;
        d0 = done_total;
        s0 = nstops;
        pulse_start();
        wait_done("t2_done", 1000);
        repeat (4) @(negedge clk);
        chk("t2_busy_cycles", 32'(busy_total - b0), 176);
        chk("t2_done_count", 32'(done_total - d0), 1);
        chk("t2_nack", 32'(nack), 1);
        chk("t2_bytes", 32'(nbytes), 1);
        chk("t2_stop", 32'(nstops - s0), 1);
        chk("t2_queue_left", 32'(exp_q.size()), 0);
        sda_in = 1'b0;

        // Inputs and i_start ignored while busy
        push_frame(7'h5D, 8'h89, 16'h4010);
        b0 = busy_total;
        d0 = done_total;
        pulse_start();
        chk("t3_nack_clear", 32'(nack), 0);
        repeat (100) @(negedge clk);
        start = 1'b1;
        data  = 16'hFFFF;
        dev   = 7'h12;
        reg_a = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done("t3_done", 1000);
        repeat (50) @(negedge clk);
        chk("t3_busy_cycles", 32'(busy_total - b0), 608);
        chk("t3_done_count", 32'(done_total - d0), 1);
        chk("t3_bytes", 32'(nbytes), 4);
        chk("t3_queue_left", 32'(exp_q.size()), 0);
        data  = 16'h4010;
        dev   = 7'h5D;
        reg_a = 8'h89;

        // Reset at busy cycle 200: mid bit 2 of the register byte
        push_frame(7'h5D, 8'h89, 16'h4010);
        pulse_start();
        repeat (200) @(negedge clk);
        chk("t4_pre_scl", 32'(scl_oe), 0);
        chk("t4_pre_sda", 32'(sda_oe), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_async_scl", 32'(scl_oe), 0);
        chk("t4_async_sda", 32'(sda_oe), 0);
        chk("t4_async_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_idle_scl", 32'(scl_oe), 0);
        chk("t4_idle_sda", 32'(sda_oe), 0);
        chk("t4_idle_busy", 32'(busy), 0);
        chk("t4_idle_done", 32'(done), 0);
        chk("t4_idle_nack", 32'(nack), 0);

        // Back-to-back with i_start held: DONE, one IDLE cycle, START
        push_frame(7'h5D, 8'h89, 16'h4010);
        push_frame(7'h5D, 8'h89, 16'h4010);
        @(negedge clk);
        start = 1'b1;
        wait_done("t5_done1", 1000);
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("t5_restart", 32'(busy), 1);
        @(negedge clk);
        chk("t5_gap", 32'(rise_cyc - done_cyc), 2);
        wait_done("t5_done2", 1000);
        repeat (4) @(negedge clk);
        chk("t5_queue_left", 32'(exp_q.size()), 0);

`ifdef PROG_CLK_STRETCH_EN
        // Slave holds SCL low for 20 cycles in the first data-bit q2
        push_frame(7'h5D, 8'h89, 16'h4010);
        b0 = busy_total;
        pulse_start();
        repeat (20) @(negedge clk);
        n = 0;
        while (scl_oe !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        scl_in = 1'b0;
        repeat (20) @(negedge clk);
        scl_in = 1'b1;
        wait_done("t6_done", 1000);
        repeat (4) @(negedge clk);
        chk("t6_busy_cycles", 32'(busy_total - b0), 628);
        chk("t6_queue_left", 32'(exp_q.size()), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
